// File: rtl/vram_arbiter_pkg.sv
// Shared constants, FSM state and issue-tag encodings for the text-RAM arbiter.
package vram_arbiter_pkg;

  localparam int         VRAM_DEPTH  = 2400;
  localparam int         VRAM_ADDR_W = 12;
  localparam int         VRAM_DATA_W = 8;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ACK  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_ACK  = 3'd3,
    ST_CLEAR   = 3'd4
  } state_e;

  // Records who owns the RAM read data arriving one cycle after issue.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_HOST = 2'd2
  } tag_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundles the video, host and RAM-side signals of the text-RAM arbiter.
interface vram_arbiter_if import vram_arbiter_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) ();

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
    output vid_data, vid_valid, host_rdata, host_ack, ram_addr, ram_we, ram_wdata, busy
  );

  // Requester / RAM environment side.
  modport master (
    output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
    input  vid_data, vid_valid, host_rdata, host_ack, ram_addr, ram_we, ram_wdata, busy
  );

endinterface

// File: rtl/vram_arbiter.sv
// Single-port text-RAM arbiter: video reads have absolute priority, host served when idle.
// Optional post-reset fill of the whole RAM with FILL_CHAR under macro VRAM_CLEAR_EN.
module vram_arbiter import vram_arbiter_pkg::*; #(
  parameter int                DEPTH     = VRAM_DEPTH,
  parameter int                ADDR_W    = VRAM_ADDR_W,
  parameter int                DATA_W    = VRAM_DATA_W,
  parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(CHAR_SPACE)
) (
  input  logic          clk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  tag_e              tag_q, tag_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_ack_q, host_ack_d;
  logic [ADDR_W-1:0] ram_addr_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              host_in_range_s;

`ifdef VRAM_CLEAR_EN
  localparam state_e            RESET_STATE = ST_CLEAR;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  // Arbitration, tag issue, data return routing and FSM next state.
  always_comb begin
    state_d         = state_q;
    tag_d           = TAG_NONE;
    ram_addr_s      = '0;
    ram_we_s        = 1'b0;
    ram_wdata_s     = FILL_CHAR;
    vid_data_d      = vid_data_q;
    vid_valid_d     = 1'b0;
    host_rdata_d    = host_rdata_q;
    host_in_range_s = ({1'b0, bus.host_addr} < DEPTH_X);
`ifdef VRAM_CLEAR_EN
    clr_cnt_d       = clr_cnt_q;
`endif

    if (tag_q == TAG_VID) begin
      vid_data_d  = bus.ram_rdata;
      vid_valid_d = 1'b1;
    end

    if (bus.vid_req) begin
      ram_addr_s = bus.vid_addr;
      tag_d      = TAG_VID;
    end else if ((state_q == ST_IDLE) && bus.host_req) begin
      state_d = bus.host_we ? ST_WR_ACK : ST_RD_WAIT;
      // Out-of-range host ops still complete, just without touching the RAM.
      if (host_in_range_s) begin
        ram_addr_s  = bus.host_addr;
        ram_we_s    = bus.host_we;
        ram_wdata_s = bus.host_wdata;
        tag_d       = TAG_HOST;
      end
    end
`ifdef VRAM_CLEAR_EN
    else if (state_q == ST_CLEAR) begin
      ram_addr_s  = clr_cnt_q;
      ram_we_s    = 1'b1;
      ram_wdata_s = FILL_CHAR;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
`endif

    case (state_q)
      ST_WR_ACK:  state_d = ST_IDLE;
      ST_RD_WAIT: begin
        host_rdata_d = (tag_q == TAG_HOST) ? bus.ram_rdata : '0;
        state_d      = ST_RD_ACK;
      end
      ST_RD_ACK:  state_d = ST_IDLE;
      default:    ;
    endcase

    host_ack_d = (state_d == ST_WR_ACK) || (state_d == ST_RD_ACK);
`ifdef VRAM_CLEAR_EN
    busy_d = (state_d == ST_CLEAR);
`endif
  end

  // State, tag pipeline and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      tag_q        <= TAG_NONE;
      vid_data_q   <= '0;
      vid_valid_q  <= 1'b0;
      host_rdata_q <= '0;
      host_ack_q   <= 1'b0;
`ifdef VRAM_CLEAR_EN
      clr_cnt_q    <= '0;
      busy_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      vid_data_q   <= vid_data_d;
      vid_valid_q  <= vid_valid_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
`ifdef VRAM_CLEAR_EN
      clr_cnt_q    <= clr_cnt_d;
      busy_q       <= busy_d;
`endif
    end
  end

  assign bus.vid_data   = vid_data_q;
  assign bus.vid_valid  = vid_valid_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.ram_addr   = ram_addr_s;
  assign bus.ram_we     = ram_we_s;
  assign bus.ram_wdata  = ram_wdata_s;
`ifdef VRAM_CLEAR_EN
  assign bus.busy       = busy_q;
`else
  assign bus.busy       = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int DEPTH = VRAM_DEPTH;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  vram_arbiter_if #(.ADDR_W(VRAM_ADDR_W), .DATA_W(VRAM_DATA_W)) bus ();

  vram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [0:4095];

  always #5 clk = ~clk;

  // Single-port synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.vid_req    = 1'b0;
    bus.vid_addr   = 12'd0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 12'd0;
    bus.host_wdata = 8'd0;
  endtask

  // Issue one host op (vid_req low), wait for ack, then drop the request.
  task automatic host_xfer(input string tag, input logic we, input logic [11:0] addr,
                           input logic [7:0] wd, input int exp_lat,
                           input logic [7:0] exp_rd, input logic exp_ram_we);
    int lat;
    lat            = -1;
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
    mid();
    check_eq({tag, "_ram_we"}, 32'(bus.ram_we), 32'(exp_ram_we));
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      mid();
      if (bus.host_ack) begin
        lat = c;
        break;
      end
    end
    check_eq({tag, "_ack_lat"}, 32'(lat), 32'(exp_lat));
    if (!we) check_eq({tag, "_rdata"}, 32'(bus.host_rdata), 32'(exp_rd));
    next_cycle();
    bus.host_req = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int bc;
    bc = 0;
    for (int c = 0; c < DEPTH + 20; c++) begin
      mid();
      if (!bus.busy) break;
      bc++;
      next_cycle();
    end
    check_eq(tag, 32'(bc), 32'(DEPTH));
    next_cycle();
  endtask

  logic [11:0] pre_addr [7] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd5, 12'd7, 12'd9};
  logic [7:0]  pre_data [7] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h33, 8'h37, 8'h39};

  initial begin
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    mid();
    check_eq("rst_vid_valid",  32'(bus.vid_valid),  32'd0);
    check_eq("rst_vid_data",   32'(bus.vid_data),   32'd0);
    check_eq("rst_host_ack",   32'(bus.host_ack),   32'd0);
    check_eq("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
`ifdef VRAM_CLEAR_EN
    check_eq("rst_busy", 32'(bus.busy), 32'd1);
`else
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
`endif
    next_cycle();
    reset = 1'b0;

`ifdef VRAM_CLEAR_EN
    wait_clear("clr_busy_cycles");
    for (int c = 0; c < DEPTH + 2; c++) begin
      bus.vid_req  = (c < DEPTH);
      bus.vid_addr = 12'(c);
      mid();
      if (c >= 2) check_eq("clr_fill", 32'(bus.vid_data), 32'h20);
      next_cycle();
    end
    bus.vid_req = 1'b0;
`endif

    // Preload through the host port; each write acks one cycle after issue.
    for (int i = 0; i < 7; i++) host_xfer("preload", 1'b1, pre_addr[i], pre_data[i], 1, 8'h00, 1'b1);

    // Video stream: 4 back-to-back reads, valid 2 cycles after each request.
    for (int c = 0; c < 7; c++) begin
      bus.vid_req  = (c < 4);
      bus.vid_addr = 12'(c);
      mid();
      check_eq("vs_valid", 32'(bus.vid_valid), 32'((c >= 2) && (c < 6)));
      if ((c >= 2) && (c < 6)) check_eq("vs_data", 32'(bus.vid_data), 32'(8'h41 + c - 2));
      next_cycle();
    end
    bus.vid_req = 1'b0;

    host_xfer("wr100", 1'b1, 12'd100, 8'h5A, 1, 8'h00, 1'b1);
    host_xfer("rd100", 1'b0, 12'd100, 8'h00, 2, 8'h5A, 1'b0);

    // Contention: host read of addr 5 starved while video reads addr 7.
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 12'd5;
    for (int c = 0; c < 10; c++) begin
      bus.vid_req  = (c < 6);
      bus.vid_addr = 12'd7;
      if (c == 9) bus.host_req = 1'b0;
      mid();
      if (c < 6) check_eq("cont_ram_addr_vid", 32'(bus.ram_addr), 32'd7);
      if (c < 6) check_eq("cont_ram_we", 32'(bus.ram_we), 32'd0);
      if (c == 6) check_eq("cont_host_issue_addr", 32'(bus.ram_addr), 32'd5);
      check_eq("cont_host_ack", 32'(bus.host_ack), 32'(c == 8));
      check_eq("cont_vid_valid", 32'(bus.vid_valid), 32'((c >= 2) && (c <= 7)));
      if ((c >= 2) && (c <= 7)) check_eq("cont_vid_data", 32'(bus.vid_data), 32'h37);
      if (c == 8) check_eq("cont_host_rdata", 32'(bus.host_rdata), 32'h33);
      next_cycle();
    end

    // Interleave: host read addr 1 in N, video read addr 9 in N+1.
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 12'd1;
    mid();
    check_eq("il_host_addr", 32'(bus.ram_addr), 32'd1);
    next_cycle();
    bus.vid_req  = 1'b1;
    bus.vid_addr = 12'd9;
    mid();
    check_eq("il_vid_addr", 32'(bus.ram_addr), 32'd9);
    check_eq("il_ack_n1", 32'(bus.host_ack), 32'd0);
    next_cycle();
    bus.vid_req = 1'b0;
    mid();
    check_eq("il_ack_n2", 32'(bus.host_ack), 32'd1);
    check_eq("il_host_rdata", 32'(bus.host_rdata), 32'h42);
    check_eq("il_vid_valid_n2", 32'(bus.vid_valid), 32'd0);
    next_cycle();
    bus.host_req = 1'b0;
    mid();
    check_eq("il_vid_valid_n3", 32'(bus.vid_valid), 32'd1);
    check_eq("il_vid_data", 32'(bus.vid_data), 32'h39);
    check_eq("il_host_rdata_hold", 32'(bus.host_rdata), 32'h42);
    check_eq("il_ack_n3", 32'(bus.host_ack), 32'd0);
    next_cycle();

    host_xfer("oor_wr", 1'b1, 12'd2400, 8'h77, 1, 8'h00, 1'b0);
    host_xfer("oor_rd", 1'b0, 12'd4095, 8'h00, 2, 8'h00, 1'b0);

    // Reset mid-read: video read in N-1, host read in N, reset in N+1.
    bus.vid_req  = 1'b1;
    bus.vid_addr = 12'd3;
    next_cycle();
    bus.vid_req   = 1'b0;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 12'd2;
    mid();
    check_eq("rmr_issue_addr", 32'(bus.ram_addr), 32'd2);
    next_cycle();
    reset        = 1'b1;
    bus.host_req = 1'b0;
    mid();
    check_eq("rmr_vid_valid", 32'(bus.vid_valid), 32'd0);
    check_eq("rmr_host_ack", 32'(bus.host_ack), 32'd0);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mid();
      check_eq("rmr_post_ack", 32'(bus.host_ack), 32'd0);
      check_eq("rmr_post_valid", 32'(bus.vid_valid), 32'd0);
      if (c < 2) next_cycle();
    end
`ifdef VRAM_CLEAR_EN
    next_cycle();
    wait_clear("rmr_reclear_cycles");
`else
    check_eq("rmr_busy", 32'(bus.busy), 32'd0);
    next_cycle();
`endif
    host_xfer("rmr_idle_wr", 1'b1, 12'd200, 8'h11, 1, 8'h00, 1'b1);
    host_xfer("rmr_idle_rd", 1'b0, 12'd200, 8'h00, 2, 8'h11, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
